// File: rtl/button_event_queue_if.sv
// Pin-side and processor-side signals of the button event queue, grouped so the
// queue and its driver share one bundle; clock and reset stay plain ports.
interface button_event_queue_if #(
    parameter int N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] buttons;
    logic                 poll_button;
    logic                 clear_overflow;
    logic [31:0]          button_out;
    logic [N_BUTTONS-1:0] pressed_level;

    modport master (
        output buttons, poll_button, clear_overflow,
        input  button_out, pressed_level
    );

    modport slave (
        input  buttons, poll_button, clear_overflow,
        output button_out, pressed_level
    );
endinterface

// File: rtl/button_event_queue.sv
// Debounces N push buttons, turns each debounced press into an index event and
// queues events in a FIFO that the processor pops one per poll via a status word.
module button_event_queue #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEPTH           = 8,
    parameter int HOLDOFF_CYCLES  = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    button_event_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HO_W  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF_CYCLES);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    function automatic logic [3:0] f_lowest_idx(input logic [N_BUTTONS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [2:0]           r_warm;
    logic                 w_arm_load;
    logic [N_BUTTONS-1:0] r_sync_p0;
    logic [N_BUTTONS-1:0] r_sync_p1;
    logic [N_BUTTONS-1:0] r_level;
    logic [CNT_W-1:0]     r_db_cnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] w_differ;
    logic [N_BUTTONS-1:0] w_flip;
    logic [N_BUTTONS-1:0] w_rise;
    logic [N_BUTTONS-1:0] w_fall;
    logic [N_BUTTONS-1:0] r_armed;
    logic [N_BUTTONS-1:0] w_armed;
    logic [N_BUTTONS-1:0] r_pending;
    logic [N_BUTTONS-1:0] w_push_onehot;
    logic                 w_push_valid;
    logic [3:0]           w_push_idx;
    logic [3:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [OCC_W-1:0]     r_occ;
    logic [OCC_W-1:0]     w_occ_next;
    logic [HO_W-1:0]      r_holdoff;
    logic                 r_ovf;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_drop;
    logic                 w_valid;
    logic [3:0]           w_head;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Stage p0/p1: two-flop synchroniser per button.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_warm    <= '0;
        end else begin
            r_sync_p0 <= bus.buttons;
            r_sync_p1 <= r_sync_p0;
            r_warm    <= {r_warm[1:0], 1'b1};
        end
    end

    // One-shot: the first cycle the synchroniser holds real pin levels.
    assign w_arm_load = r_warm[1] & ~r_warm[2];

    always_comb begin
        w_differ = r_sync_p1 ^ r_level;
        w_flip   = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            w_flip[i] = w_differ[i] && (r_db_cnt[i] == CNT_LAST);
        end
    end
    assign w_rise = w_flip &  r_sync_p1;
    assign w_fall = w_flip & ~r_sync_p1;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < N_BUTTONS; i++) r_db_cnt[i] <= '0;
            r_level <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (!w_differ[i] || w_flip[i]) r_db_cnt[i] <= '0;
                else                           r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
            end
            r_level <= r_level ^ w_flip;
        end
    end

    // A button already held when reset lifts stays disarmed until its first release.
    assign w_armed = w_arm_load ? ~r_sync_p1 : r_armed;

    assign w_push_valid  = |r_pending;
    assign w_push_onehot = r_pending & (~r_pending + N_BUTTONS'(1));
    assign w_push_idx    = f_lowest_idx(r_pending);

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_armed   <= '0;
            r_pending <= '0;
        end else begin
            r_armed   <= w_armed | w_fall;
            r_pending <= (r_pending & ~w_push_onehot) | (w_rise & w_armed);
        end
    end

    assign w_full    = (r_occ == OCC_FULL);
    assign w_pop     = bus.poll_button && (r_occ != '0) && (r_holdoff == '0);
    assign w_push_ok = w_push_valid && (!w_full || w_pop);
    assign w_drop    = w_push_valid && w_full && !w_pop;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push_ok && !w_pop)      w_occ_next = r_occ + OCC_W'(1);
        else if (!w_push_ok && w_pop) w_occ_next = r_occ - OCC_W'(1);
    end

    // Stage: FIFO storage holds data only, so it carries no reset.
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr] <= w_push_idx;
    end

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_holdoff <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
            r_occ <= w_occ_next;
            if (w_pop)                  r_holdoff <= HO_LOAD;
            else if (r_holdoff != '0)   r_holdoff <= r_holdoff - HO_W'(1);
            if (w_drop)                 r_ovf <= 1'b1;
            else if (bus.clear_overflow) r_ovf <= 1'b0;
        end
    end

    assign w_valid = (r_occ != '0) && (r_holdoff == '0);
    assign w_head  = w_valid ? r_mem[r_rptr] : 4'd0;

    assign bus.button_out    = {r_ovf, 15'd0, 8'(r_occ), 3'd0, w_head, w_valid};
    assign bus.pressed_level = r_level;
endmodule

// File: tb/tb_button_event_queue.sv
// Randomised and directed stimulus for the button event queue; a queue-based
// model predicts events and a monitor checks every accepted pop against it.
module tb_button_event_queue;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic stim_poll;
    logic mon_poll;
    logic polb;
    logic auto_pop;
    logic m_ovf;
    int   exp_q[$];
    int   exp_qb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    button_event_queue_if #(.N_BUTTONS(4)) ifa ();
    button_event_queue_if #(.N_BUTTONS(4)) ifb ();

    assign ifa.poll_button = stim_poll | mon_poll;
    assign ifb.poll_button = polb;

    button_event_queue #(
        .N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .DEPTH(4), .HOLDOFF_CYCLES(0)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(ifa)
    );

    button_event_queue #(
        .N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .DEPTH(4), .HOLDOFF_CYCLES(10)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(ifb)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Status word implied by the model queue and overflow flag.
    function automatic logic [31:0] model_status_a();
        logic [31:0] s;
        s = '0;
        s[31]   = m_ovf;
        s[15:8] = 8'(exp_q.size());
        if (exp_q.size() > 0) begin
            s[0]   = 1'b1;
            s[4:1] = 4'(exp_q[0]);
        end
        return s;
    endfunction

    task automatic check_pop(input string name, inout int q[$], input logic [3:0] idx);
        int e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event index %0d, required none", name, idx);
        end else begin
            e = q.pop_front();
            cmp(name, 32'(idx), 32'(e));
        end
    endtask

    always @(negedge clock) begin
        if (auto_pop) begin
            if (ifa.button_out[0] && !mon_poll) begin
                check_pop("pop_a_idx", exp_q, ifa.button_out[4:1]);
                mon_poll = 1'b1;
            end else begin
                mon_poll = 1'b0;
            end
        end else begin
            mon_poll = 1'b0;
            if (stim_poll && ifa.button_out[0]) check_pop("pop_a_idx", exp_q, ifa.button_out[4:1]);
        end
    end

    always @(negedge clock) begin
        if (polb && ifb.button_out[0]) check_pop("pop_b_idx", exp_qb, ifb.button_out[4:1]);
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d events outstanding, required 0", name, exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic stim_pop_a();
        stim_poll = 1'b1;
        tick();
        stim_poll = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] m;
        int         len;
        bit         glitch;

        reset_n = 1'b0;
        ifa.buttons = '0;        ifb.buttons = '0;
        ifa.clear_overflow = 0;  ifb.clear_overflow = 0;
        stim_poll = 0; polb = 0; auto_pop = 0; m_ovf = 0; mon_poll = 0;
        repeat (3) tick();
        cmp("reset_out_a", ifa.button_out, 32'h0);
        cmp("reset_out_b", ifb.button_out, 32'h0);
        reset_n = 1'b1;
        repeat (5) tick();
        cmp("idle_out_a", ifa.button_out, 32'h0);
        cmp("idle_level_a", 32'(ifa.pressed_level), 32'h0);

        // Single press: valid appears exactly 2 + D + 1 cycles after the edge.
        ifa.buttons = 4'b0010;
        exp_q.push_back(1);
        repeat (6) tick();
        cmp("single_early", ifa.button_out, 32'h0);
        tick();
        cmp("single_out", ifa.button_out, model_status_a());
        cmp("single_word", ifa.button_out, 32'h103);
        repeat (13) tick();
        cmp("single_level", 32'(ifa.pressed_level), 32'b0010);
        stim_pop_a();
        cmp("single_after_pop", ifa.button_out, 32'h0);
        ifa.buttons = 4'b0000;
        repeat (10) tick();

        // Glitch rejection then an accepted short press.
        ifa.buttons = 4'b0100;
        repeat (3) tick();
        ifa.buttons = 4'b0000;
        cmp("glitch_level", 32'(ifa.pressed_level), 32'h0);
        repeat (10) tick();
        cmp("glitch_out", ifa.button_out, 32'h0);
        ifa.buttons = 4'b0100;
        exp_q.push_back(2);
        repeat (6) tick();
        ifa.buttons = 4'b0000;
        repeat (10) tick();
        cmp("pulse6_out", ifa.button_out, model_status_a());
        stim_pop_a();
        cmp("pulse6_after_pop", ifa.button_out, 32'h0);

        // Simultaneous press queues ascending indices on consecutive cycles.
        ifa.buttons = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        repeat (7) tick();
        cmp("simul_occ1", 32'(ifa.button_out[15:8]), 32'd1);
        tick();
        cmp("simul_occ2", 32'(ifa.button_out[15:8]), 32'd2);
        tick();
        cmp("simul_out", ifa.button_out, model_status_a());
        repeat (3) tick();
        ifa.buttons = 4'b0000;
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            stim_pop_a();
            tick();
        end
        cmp("simul_drained", ifa.button_out, model_status_a());

        // Overflow: five presses into four entries.
        for (int k = 0; k < 5; k++) begin
            ifa.buttons = 4'b0001;
            if (exp_q.size() < 4) exp_q.push_back(0);
            else                  m_ovf = 1'b1;
            repeat (8) tick();
            ifa.buttons = 4'b0000;
            repeat (8) tick();
        end
        cmp("ovf_out", ifa.button_out, model_status_a());
        cmp("ovf_word", ifa.button_out, 32'h8000_0401);
        ifa.clear_overflow = 1'b1;
        tick();
        ifa.clear_overflow = 1'b0;
        m_ovf = 1'b0;
        cmp("ovf_cleared", ifa.button_out, model_status_a());
        // Push lands on the same edge as a pop while full: nothing dropped.
        ifa.buttons = 4'b0010;
        exp_q.push_back(1);
        repeat (6) tick();
        stim_pop_a();
        cmp("full_push_pop", ifa.button_out, model_status_a());
        repeat (10) tick();
        ifa.buttons = 4'b0000;
        cmp("full_push_pop_hold", ifa.button_out, model_status_a());
        auto_pop = 1'b1;
        wait_drain("ovf_drain");
        auto_pop = 1'b0;
        cmp("ovf_empty", ifa.button_out, 32'h0);

        // Holdoff instance: second head hidden for 10 cycles after a pop.
        ifb.buttons = 4'b0100; exp_qb.push_back(2);
        repeat (8) tick();
        ifb.buttons = 4'b0000;
        repeat (8) tick();
        ifb.buttons = 4'b1000; exp_qb.push_back(3);
        repeat (8) tick();
        ifb.buttons = 4'b0000;
        repeat (8) tick();
        cmp("hold_pre", ifb.button_out, 32'h205);
        polb = 1'b1;
        tick();
        polb = 1'b0;
        cmp("hold_valid0", 32'(ifb.button_out[0]), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) polb = 1'b1;
            tick();
            polb = 1'b0;
            if (k < 10) cmp("hold_window", 32'(ifb.button_out[0]), 32'd0);
            else        cmp("hold_after", ifb.button_out, 32'h107);
            if (k == 4) cmp("hold_ignored_occ", 32'(ifb.button_out[15:8]), 32'd1);
        end
        polb = 1'b1;
        tick();
        polb = 1'b0;
        cmp("hold_last_pop", 32'(ifb.button_out[15:8]), 32'd0);
        cmp("hold_queue_used", 32'(exp_qb.size()), 32'd0);

        // Async reset with three queued events and button 3 mid-debounce.
        ifa.buttons = 4'b0111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        repeat (8) tick();
        ifa.buttons = 4'b0000;
        repeat (8) tick();
        cmp("rst_pre", ifa.button_out, model_status_a());
        ifa.buttons = 4'b1000;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        cmp("rst_immediate", ifa.button_out, 32'h0);
        cmp("rst_level", 32'(ifa.pressed_level), 32'h0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        cmp("rst_held_no_event", ifa.button_out, 32'h0);
        cmp("rst_held_level", 32'(ifa.pressed_level), 32'b1000);
        ifa.buttons = 4'b0000;
        repeat (10) tick();
        ifa.buttons = 4'b1000;
        exp_q.push_back(3);
        repeat (8) tick();
        ifa.buttons = 4'b0000;
        repeat (8) tick();
        cmp("rst_repress", ifa.button_out, model_status_a());
        auto_pop = 1'b1;
        wait_drain("rst_drain");

        // Randomised presses and glitches, drained by the monitor.
        for (int it = 0; it < 14; it++) begin
            m      = 4'($urandom_range(1, 15));
            glitch = ($urandom_range(0, 2) == 0);
            len    = glitch ? $urandom_range(1, D - 1) : $urandom_range(D + 3, 12);
            ifa.buttons = m;
            if (!glitch) begin
                for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(i);
            end
            repeat (len) tick();
            cmp("rand_level", 32'(ifa.pressed_level), glitch ? 32'h0 : 32'(m));
            ifa.buttons = 4'b0000;
            repeat (D + 4) tick();
            wait_drain("rand_drain");
            cmp("rand_idle", ifa.button_out, 32'h0);
        end
        auto_pop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
